// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction, holds it in the IR until the
// executor signals completion, then selects the next pc (jump, branch or sequential).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemValid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        stepDone,
  input  logic [1:0]  branch,
  input  logic        branchTaken,
  input  logic [15:0] branchOffset,
  input  logic [1:0]  jump,
  input  logic [25:0] jumpTarget,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instrCount
);

  typedef enum logic [1:0] {StFetch, StHold, StHalted, StFault} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  wait_q, wait_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic [31:0] next_pc;
  logic [7:0]  wait_inc;

  assign pc_plus4   = pc_q + 32'd4;
  assign jump_tgt   = {pc_plus4[31:28], jumpTarget, 2'b00};
  assign branch_tgt = pc_plus4 + {{14{branchOffset[15]}}, branchOffset, 2'b00};
  assign wait_inc   = wait_q + 8'd1;

  // Jump outranks a taken branch; anything else falls through sequentially.
  always_comb begin
    next_pc = pc_plus4;
    if (jump == 2'b10) begin
      next_pc = jump_tgt;
    end else if (branch == 2'b01 && branchTaken) begin
      next_pc = branch_tgt;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    wait_d  = wait_q;
    unique case (state_q)
      StFetch: begin
        if (imemValid) begin
          instr_d = imemRdata;
          wait_d  = 8'd0;
          state_d = StHold;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TimeoutCnt) begin
            state_d = StFault;
          end
        end
      end
      StHold: begin
        if (stepDone) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          // A misaligned target still retires the instruction but stops the core.
          if (next_pc[1:0] != 2'b00) begin
            state_d = StFault;
          end else if (halt) begin
            state_d = StHalted;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StHalted: state_d = StHalted;
      StFault:  state_d = StFault;
      default:  state_d = StFault;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      count_q <= 32'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  // Request is gated by reset so it stays low while rst_n is held.
  assign imemReq    = rst_n && (state_q == StFetch);
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign instrValid = (state_q == StHold);
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign halted     = (state_q == StHalted);
  assign fault      = (state_q == StFault);
  assign instrCount = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table of fetch/step transactions plus
// hand-written sequences for jump at a high address, async reset and memory timeout.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imemRdata = 32'd0;
  logic        imemValid = 1'b0;
  logic        stepDone = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic        branchTaken = 1'b0;
  logic [15:0] branchOffset = 16'd0;
  logic [1:0]  jump = 2'b00;
  logic [25:0] jumpTarget = 26'd0;
  logic        halt = 1'b0;

  logic        imemReq, instrValid, halted, fault;
  logic [31:0] imemAddr, instr, pc, pcPlus4, instrCount;
  logic [5:0]  opcode;

  logic        h_imemReq, h_instrValid, h_halted, h_fault;
  logic [31:0] h_imemAddr, h_instr, h_pc, h_pcPlus4, h_instrCount;
  logic [5:0]  h_opcode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemRdata(imemRdata), .imemValid(imemValid), .instr(instr), .opcode(opcode),
    .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4), .stepDone(stepDone),
    .branch(branch), .branchTaken(branchTaken), .branchOffset(branchOffset),
    .jump(jump), .jumpTarget(jumpTarget), .halt(halt), .halted(halted),
    .fault(fault), .instrCount(instrCount)
  );

  // Second instance starts at a high address so the jump region case is reachable.
  instruction_fetch_unit #(.RESET_PC(32'h1000_0010), .MEM_TIMEOUT(16)) u_hi (
    .clk(clk), .rst_n(rst_n), .imemReq(h_imemReq), .imemAddr(h_imemAddr),
    .imemRdata(imemRdata), .imemValid(imemValid), .instr(h_instr), .opcode(h_opcode),
    .instrValid(h_instrValid), .pc(h_pc), .pcPlus4(h_pcPlus4), .stepDone(stepDone),
    .branch(branch), .branchTaken(branchTaken), .branchOffset(branchOffset),
    .jump(jump), .jumpTarget(jumpTarget), .halt(halt), .halted(h_halted),
    .fault(h_fault), .instrCount(h_instrCount)
  );

  typedef struct {
    logic [31:0] word;
    int          dly;
    logic [1:0]  br;
    logic        tk;
    logic [15:0] off;
    logic [1:0]  jp;
    logic [25:0] tgt;
    logic        hlt;
    logic [31:0] cur_pc;
    logic [31:0] nxt_pc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imemValid = 1'b0;
    stepDone = 1'b0;
    @(negedge clk);
    chk("rst_req", imemReq, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ivalid", instrValid, 0);
    chk("rst_count", instrCount, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_after_rst", imemReq, 1);
    chk("addr_after_rst", imemAddr, 32'h0);
  endtask

  // Called mid-cycle while in FETCH; leaves the DUT in HOLD at posedge+1.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word, input int dly);
    chk("fetch_req", imemReq, 1);
    chk("fetch_addr", imemAddr, exp_pc);
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    imemValid = 1'b1;
    imemRdata = word;
    @(posedge clk);
    #1;
    imemValid = 1'b0;
    chk("hold_ivalid", instrValid, 1);
    chk("hold_req", imemReq, 0);
    chk("hold_instr", instr, word);
    chk("hold_opcode", opcode, word[31:26]);
    chk("hold_pc", pc, exp_pc);
    chk("hold_pc4", pcPlus4, exp_pc + 32'd4);
  endtask

  task automatic do_step(input logic [1:0] br, input logic tk, input logic [15:0] off,
                         input logic [1:0] jp, input logic [25:0] tgt, input logic hlt);
    stepDone = 1'b1;
    branch = br;
    branchTaken = tk;
    branchOffset = off;
    jump = jp;
    jumpTarget = tgt;
    halt = hlt;
    @(posedge clk);
    #1;
    stepDone = 1'b0;
    branch = 2'b00;
    branchTaken = 1'b0;
    branchOffset = 16'd0;
    jump = 2'b00;
    jumpTarget = 26'd0;
    halt = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h2001_0001, 1, 2'b00, 1'b0, 16'h0000, 2'b00, 26'h0, 1'b0, 32'h0, 32'h4};
    vecs[1]  = '{32'h2002_0002, 1, 2'b00, 1'b0, 16'h0000, 2'b00, 26'h0, 1'b0, 32'h4, 32'h8};
    vecs[2]  = '{32'h2003_0003, 1, 2'b00, 1'b0, 16'h0000, 2'b00, 26'h0, 1'b0, 32'h8, 32'hC};
    vecs[3]  = '{32'h0800_0008, 0, 2'b00, 1'b0, 16'h0000, 2'b10, 26'h8, 1'b0, 32'hC, 32'h20};
    vecs[4]  = '{32'h1000_FFFE, 2, 2'b01, 1'b0, 16'hFFFE, 2'b00, 26'h0, 1'b0, 32'h20, 32'h24};
    vecs[5]  = '{32'h0800_0008, 1, 2'b00, 1'b0, 16'h0000, 2'b10, 26'h8, 1'b0, 32'h24, 32'h20};
    vecs[6]  = '{32'h1000_FFFE, 1, 2'b01, 1'b1, 16'hFFFE, 2'b00, 26'h0, 1'b0, 32'h20, 32'h1C};
    vecs[7]  = '{32'h1400_0010, 3, 2'b10, 1'b1, 16'h0010, 2'b00, 26'h0, 1'b0, 32'h1C, 32'h20};
    vecs[8]  = '{32'h0C00_0100, 1, 2'b00, 1'b0, 16'h0000, 2'b01, 26'h100, 1'b0, 32'h20, 32'h24};
    vecs[9]  = '{32'h0800_0040, 1, 2'b01, 1'b1, 16'h0005, 2'b10, 26'h40, 1'b0, 32'h24, 32'h100};
    vecs[10] = '{32'h1000_0003, 0, 2'b01, 1'b1, 16'h0003, 2'b00, 26'h0, 1'b0, 32'h100, 32'h110};
    vecs[11] = '{32'h1000_FFBA, 1, 2'b01, 1'b1, 16'hFFBA, 2'b00, 26'h0, 1'b0, 32'h110,
                 32'hFFFF_FFFC};
    vecs[12] = '{32'h2004_0004, 1, 2'b00, 1'b0, 16'h0000, 2'b00, 26'h0, 1'b0, 32'hFFFF_FFFC,
                 32'h0};
    vecs[13] = '{32'hFC00_0000, 1, 2'b00, 1'b0, 16'h0000, 2'b00, 26'h0, 1'b1, 32'h0, 32'h4};

    // Reset state, checked before any clock edge.
    #2;
    chk("init_req", imemReq, 0);
    chk("init_instr", instr, 0);
    chk("init_halted", halted, 0);
    chk("init_fault", fault, 0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      do_fetch(vecs[i].cur_pc, vecs[i].word, vecs[i].dly);
      do_step(vecs[i].br, vecs[i].tk, vecs[i].off, vecs[i].jp, vecs[i].tgt, vecs[i].hlt);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].nxt_pc);
      chk($sformatf("v%0d_count", i), instrCount, 32'(i + 1));
      chk($sformatf("v%0d_fault", i), fault, 0);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].hlt);
      chk($sformatf("v%0d_req", i), imemReq, !vecs[i].hlt);
      if (!vecs[i].hlt) chk($sformatf("v%0d_addr", i), imemAddr, vecs[i].nxt_pc);
    end

    // Halted: memory and step inputs are ignored, nothing more is requested.
    imemValid = 1'b1;
    stepDone = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("halt_req", imemReq, 0);
      chk("halt_flag", halted, 1);
      chk("halt_ivalid", instrValid, 0);
    end
    chk("halt_count", instrCount, 32'd14);
    imemValid = 1'b0;
    stepDone = 1'b0;

    // Jump from 0x1000_0010 keeps the upper nibble of pc+4.
    do_reset();
    chk("hi_addr0", h_imemAddr, 32'h1000_0010);
    do_fetch(32'h0, 32'h0800_0040, 1);
    chk("hi_opcode", h_opcode, 6'b000010);
    imemValid = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imemValid = 1'b0;
    chk("hold_ignores_valid", instr, 32'h0800_0040);
    chk("hold_stays", instrValid, 1);
    do_step(2'b00, 1'b0, 16'h0, 2'b10, 26'h40, 1'b0);
    chk("hi_jump_addr", h_imemAddr, 32'h1000_0100);
    chk("lo_jump_addr", imemAddr, 32'h0000_0100);

    // Asynchronous reset in the middle of HOLD discards the instruction.
    do_reset();
    do_fetch(32'h0, 32'h2001_0001, 1);
    do_step(2'b00, 1'b0, 16'h0, 2'b00, 26'h0, 1'b0);
    do_fetch(32'h4, 32'h2002_0002, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ivalid", instrValid, 0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_count", instrCount, 0);
    chk("arst_req", imemReq, 0);
    chk("arst_instr", instr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_fetch(32'h0, 32'h2005_0005, 1);
    chk("arst_refetch_count", instrCount, 0);

    // Timeout: 15 empty cycles are tolerated, the 16th faults; stepDone is ignored in FETCH.
    do_reset();
    stepDone = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("to_fault_early", fault, 0);
    chk("to_req_early", imemReq, 1);
    @(posedge clk);
    #1;
    chk("to_fault", fault, 1);
    chk("to_req", imemReq, 0);
    chk("to_ivalid", instrValid, 0);
    chk("to_count", instrCount, 0);
    imemValid = 1'b1;
    imemRdata = 32'h1234_5678;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("to_fault_sticky", fault, 1);
    chk("to_req_after", imemReq, 0);
    chk("to_instr", instr, 0);
    imemValid = 1'b0;
    stepDone = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- RESET_PC, default 32'h0000_0000, first fetch address.
- MEM_TIMEOUT, default 16, maximum wait cycles for imemValid; legal range 1..255.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imemReq  out  1  instruction memory read request.
- imemAddr  out  32  word-aligned fetch address.
- imemRdata  in  32  instruction word.
- imemValid  in  1  imemRdata valid this cycle.
- instr  out  32  instruction register (IR).
- opcode  out  6  IR[31:26]; drives the decoder opcode input.
- instrValid  out  1  IR holds an instruction awaiting execution.
- pc  out  32  address of IR.
- pcPlus4  out  32  pc+4.
- stepDone  in  1  current instruction finished executing.
- branch  in  2  decoder branch control.
- branchTaken  in  1  branch condition true.
- branchOffset  in  16  signed word offset.
- jump  in  2  decoder jump control.
- jumpTarget  in  26  jump index field.
- halt  in  1  stop fetching after the current instruction.
- halted  out  1  core stopped cleanly.
- fault  out  1  fetch fault latched.
- instrCount  out  32  retired instruction count.

Function
REQ-003 The FSM SHALL have exactly the states FETCH, HOLD, HALTED and FAULT.
REQ-004 In FETCH:
- imemReq=1 and imemAddr=pc.
- At an edge where imemValid=1: load IR=imemRdata and go to HOLD.
REQ-005 Latency: instrValid SHALL be 1 in the cycle after the imemValid edge. The instruction takes minimum 1 cycle in FETCH plus 1 cycle in HOLD.
REQ-006 In FETCH, a wait counter SHALL count cycles with imemValid=0. If it reaches MEM_TIMEOUT, go to FAULT without loading IR.
REQ-007 In HOLD:
- instrValid=1, imemReq=0.
- IR and pc SHALL stay stable until stepDone=1.
REQ-008 When stepDone=1 in HOLD, next pc SHALL be selected in this priority:
- jump==2'b10: {pcPlus4[31:28], jumpTarget, 2'b00}.
- branch==2'b01 and branchTaken=1: pcPlus4 + (sign-extended branchOffset << 2).
- otherwise pcPlus4.
REQ-009 On that same stepDone edge:
- instrCount SHALL increment by 1.
- State SHALL become HALTED if halt=1, else FETCH.
REQ-010 halt SHALL win over a simultaneous fetch. The pc update and count increment SHALL still occur on that edge.
REQ-011 All pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000. instrCount SHALL also wrap.
REQ-012 If a selected next pc has bits [1:0] != 0:
- The state SHALL go to FAULT.
- pc SHALL still be loaded with the misaligned value.
- instrCount SHALL still increment.
REQ-013 imemValid SHALL be ignored outside FETCH. stepDone, branch and jump SHALL be ignored outside HOLD.
REQ-014 HALTED: halted=1, imemReq=0, instrValid=0; remain until reset.
REQ-015 FAULT: fault=1, imemReq=0, instrValid=0; remain until reset.
REQ-016 opcode SHALL always equal instr[31:26], and pcPlus4 SHALL always equal pc+4, combinationally.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force:
- state FETCH
- pc=RESET_PC
- instr=0, instrCount=0, wait counter 0
- instrValid=0, halted=0, fault=0
REQ-018 imemReq SHALL be 0 while rst_n=0.
REQ-019 imemReq SHALL rise in the first cycle after rst_n deasserts.
REQ-020 Reset asserted mid-fetch or mid-HOLD SHALL discard the pending instruction. No instrCount increment for it.

Verification
REQ-021 Sequential fetch:
- Stimulus: memory returns valid 1 cycle after each request; stepDone pulsed in each HOLD.
- Required: imemAddr sequence 0,4,8; instrCount=3 after third stepDone.
REQ-022 Jump:
- Stimulus: pc=32'h1000_0010; IR opcode 6'b000010; jump=2'b10; jumpTarget=26'h0000040.
- Required: next imemAddr=32'h1000_0100.
REQ-023 Branch:
- Stimulus: pc=32'h0000_0020; branch=2'b01; branchTaken=1; branchOffset=16'hFFFE.
- Required: next pc=32'h0000_001C.
- Same case with branchTaken=0: next pc=32'h0000_0024.
REQ-024 Timeout:
- Stimulus: imemValid held 0 with MEM_TIMEOUT=16.
- Required: fault=1 after 16 waiting cycles; imemReq=0 thereafter.
REQ-025 Wrap and misalignment:
- pc=32'hFFFF_FFFC, sequential step -> pc=0, no fault.
- jumpTarget causing misalignment is impossible, so inject branchOffset producing an aligned target. Then confirm halt plus stepDone gives halted=1 and no further imemReq.
REQ-026 Async reset:
- Stimulus: rst_n pulsed low mid-HOLD, between clock edges.
- Required: instrValid=0 and pc=RESET_PC before the next edge; fetch restarts at RESET_PC.
